// File: rtl/tx_forward_scheduler_pkg.sv
// Shared types and constants for the port-2 transmit forward scheduler.
package tx_sched_pkg;

  localparam logic [11:0] MIN_FRAME  = 12'd60;
  localparam logic [11:0] MAX_FRAME  = 12'd1518;
  localparam int unsigned BEAT_BYTES = 8;

  // One saved packet: DDR slot start address and byte length.
  typedef struct packed {
    logic [24:0] addr;
    logic [11:0] size;
  } desc_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  function automatic logic frame_ok(input logic [11:0] size);
    return (size >= MIN_FRAME) && (size <= MAX_FRAME);
  endfunction

  // Pacing interval after a send: packet beat count rounded up, plus the gap.
  function automatic logic [9:0] wait_cycles(input logic [11:0] size, input int unsigned gap);
    logic [12:0] beats;
    beats = (13'(size) + 13'(BEAT_BYTES - 1)) >> $clog2(BEAT_BYTES);
    return 10'(beats) + 10'(gap);
  endfunction

endpackage

// File: rtl/tx_forward_scheduler_if.sv
// Receive-side notification and transmit-side command bundle of the scheduler.
interface tx_forward_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  logic                          rx_data_saved;
  logic [11:0]                   rx_size_received;
  logic                          enable;
  logic [24:0]                   tx_start_ram_addr;
  logic                          tx_cmd_send;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic [15:0]                   drop_count;
  logic [15:0]                   sent_count;

  // Environment side: reports saved packets, observes send commands.
  modport master (
    output rx_data_saved, rx_size_received, enable,
    input  tx_start_ram_addr, tx_cmd_send, busy, fifo_level, drop_count, sent_count
  );

  // Scheduler side.
  modport slave (
    input  rx_data_saved, rx_size_received, enable,
    output tx_start_ram_addr, tx_cmd_send, busy, fifo_level, drop_count, sent_count
  );
endinterface

// File: rtl/tx_forward_scheduler_fifo.sv
// Synchronous descriptor FIFO. A push while full is accepted only if a pop
// happens in the same cycle.
module sched_desc_fifo
  import tx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  desc_t                       push_data_i,
  input  logic                        pop_i,
  output desc_t                       head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  desc_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LvlW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LvlW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tx_forward_scheduler.sv
// Paced replay scheduler for SFP port 2: queues saved-packet descriptors and
// issues spaced send commands to the transmit controller.
// Optional feature macro: TX_SCHED_STATS_EN enables drop/sent counters;
// when undefined both counter outputs read 0.
module tx_forward_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned SLOT_STRIDE = 256,
  parameter int unsigned GAP_CYCLES  = 12
) (
  input  logic            clk,
  input  logic            reset,
  tx_forward_scheduler_if.slave bus_io
);

  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH) + 1;

  logic [SlotW-1:0] slot_ptr_q, slot_ptr_d;
  desc_t            rx_desc, head;
  logic             push, pop, fifo_full, fifo_empty;
  logic [LvlW-1:0]  fifo_level;

  state_e           state_q;
  logic             cmd_send_q;
  logic [24:0]      addr_q;
  logic [11:0]      size_q;
  logic [9:0]       wait_cnt_q;

  assign rx_desc.addr = 25'(slot_ptr_q) * 25'(SLOT_STRIDE);
  assign rx_desc.size = bus_io.rx_size_received;

  // A full FIFO still takes the packet if the head leaves this same cycle.
  assign pop  = (state_q == IDLE) && bus_io.enable && !fifo_empty;
  assign push = bus_io.rx_data_saved && frame_ok(bus_io.rx_size_received) && (!fifo_full || pop);

  assign slot_ptr_d = (NUM_SLOTS > 1) ? slot_ptr_q + SlotW'(1) : '0;

  // Slot pointer follows every saved packet, dropped or not, to stay aligned
  // with the receive writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_ptr_q <= '0;
    end else if (bus_io.rx_data_saved) begin
      slot_ptr_q <= slot_ptr_d;
    end
  end

  sched_desc_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (rx_desc),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // Send sequencer: pop -> one-cycle command -> fixed pacing wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_send_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_send_q <= 1'b0;
          if (pop) begin
            addr_q     <= head.addr;
            size_q     <= head.size;
            cmd_send_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_send_q <= 1'b0;
          wait_cnt_q <= wait_cycles(size_q, GAP_CYCLES);
          state_q    <= WAIT;
        end
        WAIT: begin
          // Leaving on count 1 makes WAIT last exactly the loaded count.
          if (wait_cnt_q <= 10'd1) begin
            wait_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 10'd1;
          end
        end
        default: begin
          cmd_send_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.tx_cmd_send       = cmd_send_q;
  assign bus_io.tx_start_ram_addr = addr_q;
  assign bus_io.busy              = (state_q != IDLE) || !fifo_empty;
  assign bus_io.fifo_level        = fifo_level;

`ifdef TX_SCHED_STATS_EN
  logic        drop;
  logic [15:0] drop_count_q, sent_count_q;

  assign drop = bus_io.rx_data_saved && !push;

  // Statistics: drops saturate, sends wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
      sent_count_q <= '0;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      if (state_q == ISSUE) sent_count_q <= sent_count_q + 16'd1;
    end
  end

  assign bus_io.drop_count = drop_count_q;
  assign bus_io.sent_count = sent_count_q;
`else
  assign bus_io.drop_count = '0;
  assign bus_io.sent_count = '0;
`endif

endmodule

// File: tb/tb_tx_forward_scheduler.sv
// Directed bench for tx_forward_scheduler: latency, pacing, filtering,
// overflow, slot wrap, enable hold and mid-operation reset.
module tb_tx_forward_scheduler;

`ifdef TX_SCHED_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tx_forward_scheduler_if #(.FIFO_DEPTH(8)) bus ();

  tx_forward_scheduler #(
    .FIFO_DEPTH  (8),
    .NUM_SLOTS   (16),
    .SLOT_STRIDE (256),
    .GAP_CYCLES  (12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          cmd_cyc[$];
  logic [24:0] cmd_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every send command with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.tx_cmd_send === 1'b1) begin
      cmd_cyc.push_back(cyc);
      cmd_addr.push_back(bus.tx_start_ram_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_data_saved = 1'b0;
    bus.rx_size_received = '0;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmd_cyc.delete();
    cmd_addr.delete();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [11:0] sz);
    bus.rx_data_saved = 1'b1;
    bus.rx_size_received = sz;
    @(negedge clk);
    bus.rx_data_saved = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (bus.busy !== 1'b0 && t < bound) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.tx_cmd_send !== 1'b0) begin errors++; $display("FAIL reset_cmd: got %0b want 0", bus.tx_cmd_send); end
    checks++; if (bus.tx_start_ram_addr !== 25'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.tx_start_ram_addr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
    checks++; if (bus.sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent: got %0d want 0", bus.sent_count); end
  endtask

  task automatic test_single();
    int c;
    do_reset();
    bus.enable = 1'b1;
    c = cyc;
    pulse(12'd64);
    checks++; if (bus.fifo_level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", bus.fifo_level); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", bus.busy); end
    wait_idle(100);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", bus.busy); end
    checks++; if (cyc !== c + 23) begin errors++; $display("FAIL single_busy_fall: got cycle %0d want %0d", cyc, c + 23); end
    checks++; if (cmd_cyc.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", cmd_cyc.size()); end
    if (cmd_cyc.size() > 0) begin
      checks++; if (cmd_cyc[0] !== c + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", cmd_cyc[0], c + 2); end
      checks++; if (cmd_addr[0] !== 25'h0) begin errors++; $display("FAIL single_addr: got %0h want 0", cmd_addr[0]); end
    end
    checks++; if (bus.sent_count !== (StatsEn ? 16'd1 : 16'd0)) begin errors++; $display("FAIL single_sent: got %0d want %0d", bus.sent_count, StatsEn ? 1 : 0); end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    bus.enable = 1'b1;
    c = cyc;
    repeat (3) pulse(12'd64);
    wait_idle(200);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b want 0", bus.busy); end
    checks++; if (cmd_cyc.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", cmd_cyc.size()); end
    if (cmd_cyc.size() == 3) begin
      checks++; if (cmd_cyc[0] !== c + 2) begin errors++; $display("FAIL b2b_first: got cycle %0d want %0d", cmd_cyc[0], c + 2); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (cmd_addr[i] !== 25'(i * 256)) begin errors++; $display("FAIL b2b_addr%0d: got %0h want %0h", i, cmd_addr[i], i * 256); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (cmd_cyc[i] - cmd_cyc[i-1] !== 22) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 22", i, cmd_cyc[i] - cmd_cyc[i-1]); end
      end
    end
    checks++; if (bus.sent_count !== (StatsEn ? 16'd3 : 16'd0)) begin errors++; $display("FAIL b2b_sent: got %0d want %0d", bus.sent_count, StatsEn ? 3 : 0); end
  endtask

  task automatic test_length_filter();
    int c;
    do_reset();
    bus.enable = 1'b1;
    pulse(12'd59);
    pulse(12'd1519);
    repeat (3) @(negedge clk);
    checks++; if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL len_level: got %0d want 0", bus.fifo_level); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len_busy: got %0b want 0", bus.busy); end
    checks++; if (cmd_cyc.size() !== 0) begin errors++; $display("FAIL len_nosend: got %0d want 0", cmd_cyc.size()); end
    checks++; if (bus.drop_count !== (StatsEn ? 16'd2 : 16'd0)) begin errors++; $display("FAIL len_drop: got %0d want %0d", bus.drop_count, StatsEn ? 2 : 0); end
    c = cyc;
    pulse(12'd60);
    wait_idle(100);
    pulse(12'd1518);
    wait_idle(300);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len_idle: got %0b want 0", bus.busy); end
    checks++; if (cmd_cyc.size() !== 2) begin errors++; $display("FAIL len_count: got %0d want 2", cmd_cyc.size()); end
    if (cmd_cyc.size() == 2) begin
      checks++; if (cmd_cyc[0] !== c + 2) begin errors++; $display("FAIL len_latency: got cycle %0d want %0d", cmd_cyc[0], c + 2); end
      checks++; if (cmd_addr[0] !== 25'h200) begin errors++; $display("FAIL len_addr60: got %0h want 200", cmd_addr[0]); end
      checks++; if (cmd_addr[1] !== 25'h300) begin errors++; $display("FAIL len_addr1518: got %0h want 300", cmd_addr[1]); end
    end
    checks++; if (bus.drop_count !== (StatsEn ? 16'd2 : 16'd0)) begin errors++; $display("FAIL len_drop_after: got %0d want %0d", bus.drop_count, StatsEn ? 2 : 0); end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (10) pulse(12'd64);
    @(negedge clk);
    checks++; if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", bus.fifo_level); end
    checks++; if (bus.drop_count !== (StatsEn ? 16'd2 : 16'd0)) begin errors++; $display("FAIL ovf_drop: got %0d want %0d", bus.drop_count, StatsEn ? 2 : 0); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %0b want 1", bus.busy); end
    checks++; if (cmd_cyc.size() !== 0) begin errors++; $display("FAIL ovf_nosend: got %0d want 0", cmd_cyc.size()); end
    bus.enable = 1'b1;
    wait_idle(400);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %0b want 0", bus.busy); end
    checks++; if (cmd_cyc.size() !== 8) begin errors++; $display("FAIL ovf_count: got %0d want 8", cmd_cyc.size()); end
    if (cmd_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (cmd_addr[i] !== 25'(i * 256)) begin errors++; $display("FAIL ovf_addr%0d: got %0h want %0h", i, cmd_addr[i], i * 256); end
      end
    end
    checks++; if (bus.sent_count !== (StatsEn ? 16'd8 : 16'd0)) begin errors++; $display("FAIL ovf_sent: got %0d want %0d", bus.sent_count, StatsEn ? 8 : 0); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    repeat (8) pulse(12'd64);
    checks++; if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL fpp_full: got %0d want 8", bus.fifo_level); end
    bus.enable = 1'b1;
    pulse(12'd64);
    checks++; if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL fpp_level: got %0d want 8", bus.fifo_level); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL fpp_drop: got %0d want 0", bus.drop_count); end
    wait_idle(400);
    checks++; if (cmd_cyc.size() !== 9) begin errors++; $display("FAIL fpp_count: got %0d want 9", cmd_cyc.size()); end
    if (cmd_cyc.size() == 9) begin
      checks++; if (cmd_addr[8] !== 25'h800) begin errors++; $display("FAIL fpp_addr: got %0h want 800", cmd_addr[8]); end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    bus.enable = 1'b1;
    pulse(12'd64);
    pulse(12'd64);
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (cmd_cyc.size() !== 1) begin errors++; $display("FAIL hold_count: got %0d want 1", cmd_cyc.size()); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %0b want 1", bus.busy); end
    checks++; if (bus.fifo_level !== 4'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", bus.fifo_level); end
    bus.enable = 1'b1;
    wait_idle(100);
    checks++; if (cmd_cyc.size() !== 2) begin errors++; $display("FAIL hold_resume: got %0d want 2", cmd_cyc.size()); end
    if (cmd_cyc.size() == 2) begin
      checks++; if (cmd_addr[1] !== 25'h100) begin errors++; $display("FAIL hold_addr: got %0h want 100", cmd_addr[1]); end
    end
  endtask

  task automatic test_slot_wrap();
    do_reset();
    bus.enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      pulse(12'd64);
      wait_idle(100);
    end
    checks++; if (cmd_cyc.size() !== 17) begin errors++; $display("FAIL wrap_count: got %0d want 17", cmd_cyc.size()); end
    if (cmd_cyc.size() == 17) begin
      checks++; if (cmd_addr[15] !== 25'hF00) begin errors++; $display("FAIL wrap_addr15: got %0h want f00", cmd_addr[15]); end
      checks++; if (cmd_addr[16] !== 25'h0) begin errors++; $display("FAIL wrap_addr16: got %0h want 0", cmd_addr[16]); end
    end
    checks++; if (bus.sent_count !== (StatsEn ? 16'd17 : 16'd0)) begin errors++; $display("FAIL wrap_sent: got %0d want %0d", bus.sent_count, StatsEn ? 17 : 0); end
  endtask

  task automatic test_reset_mid();
    int n;
    int c;
    do_reset();
    bus.enable = 1'b1;
    pulse(12'd59);
    repeat (4) pulse(12'd64);
    checks++; if (bus.fifo_level !== 4'd3) begin errors++; $display("FAIL rmid_level: got %0d want 3", bus.fifo_level); end
    repeat (6) @(negedge clk);
    checks++; if (bus.tx_start_ram_addr !== 25'h100) begin errors++; $display("FAIL rmid_addr_pre: got %0h want 100", bus.tx_start_ram_addr); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_start_ram_addr !== 25'h0) begin errors++; $display("FAIL rmid_addr: got %0h want 0", bus.tx_start_ram_addr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL rmid_level0: got %0d want 0", bus.fifo_level); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL rmid_drop: got %0d want 0", bus.drop_count); end
    checks++; if (bus.sent_count !== 16'd0) begin errors++; $display("FAIL rmid_sent: got %0d want 0", bus.sent_count); end
    @(negedge clk);
    reset = 1'b0;
    n = cmd_cyc.size();
    checks++; if (n !== 1) begin errors++; $display("FAIL rmid_pre_count: got %0d want 1", n); end
    repeat (60) @(negedge clk);
    checks++; if (cmd_cyc.size() !== n) begin errors++; $display("FAIL rmid_nosend: got %0d want %0d", cmd_cyc.size(), n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got %0b want 0", bus.busy); end
    c = cyc;
    pulse(12'd64);
    wait_idle(100);
    checks++; if (cmd_cyc.size() !== n + 1) begin errors++; $display("FAIL rmid_new_count: got %0d want %0d", cmd_cyc.size(), n + 1); end
    if (cmd_cyc.size() == n + 1) begin
      checks++; if (cmd_cyc[n] !== c + 2) begin errors++; $display("FAIL rmid_new_lat: got cycle %0d want %0d", cmd_cyc[n], c + 2); end
      checks++; if (cmd_addr[n] !== 25'h0) begin errors++; $display("FAIL rmid_new_addr: got %0h want 0", cmd_addr[n]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_data_saved = 1'b0;
    bus.rx_size_received = '0;
    bus.enable = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_length_filter();
    test_overflow();
    test_full_push_pop();
    test_enable_hold();
    test_slot_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_forward_scheduler.md
# tx_forward_scheduler

Sits between the receive path of SFP port 2 and the transmit controller of port 2, which replays packets from DDR. For each saved packet it records the DDR slot and length as a descriptor in a small FIFO. It then issues paced send commands (start address plus a one-cycle command pulse) to the transmit controller. Sends are spaced by the packet's beat count plus a fixed inter-packet gap, because the transmit controller has no completion handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8: descriptor FIFO entries; power of 2, at least 2.
- NUM_SLOTS, 16: DDR receive slots used by the receive writer; power of 2.
- SLOT_STRIDE, 256: DDR address step between slots, in address units.
- GAP_CYCLES, 12: idle cycles added after each packet's beat time.

Ports:
- clk  in  1  single clock for the block (DDR Avalon clock domain).
- reset  in  1  asynchronous, active-high reset.
- rx_data_saved  in  1  single-cycle pulse: one packet fully written to the current slot.
- rx_size_received  in  12  packet length in bytes; valid in the same cycle as rx_data_saved.
- enable  in  1  level; while low, no new sends start.
- tx_start_ram_addr  out  25  DDR start address of the packet being sent.
- tx_cmd_send  out  1  single-cycle send command.
- busy  out  1  high whenever the state is not IDLE or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of descriptors.
- drop_count  out  16  count of dropped packets; saturates at 0xFFFF.
- sent_count  out  16  count of issued sends; wraps around.

## Operation
- **Slot pointer**
  - Advances by 1 (mod NUM_SLOTS) on every rx_data_saved pulse, including pulses whose packet is dropped, so it stays aligned with the receive writer.
  - Descriptor address = slot_ptr * SLOT_STRIDE, using the pointer value before the increment.
- **Length filter**
  - Sizes below 60 or above 1518 are dropped and drop_count increments.
  - Otherwise the descriptor {address, size} is pushed to the FIFO.
- **FIFO full**
  - With no pop in the same cycle, the packet is dropped and drop_count increments.
  - With a pop in the same cycle, the push is accepted.
- **State machine (IDLE, ISSUE, WAIT)**
  - IDLE: when enable=1 and the FIFO is non-empty, pop the head, latch the descriptor, go to ISSUE.
  - ISSUE (one cycle): tx_cmd_send=1, tx_start_ram_addr = latched address, sent_count++. Load wait_cnt = ((size+7)>>3) + GAP_CYCLES; go to WAIT.
  - WAIT: decrement wait_cnt; when it reaches 0, go to IDLE. WAIT always lasts exactly the loaded count of cycles.
  - enable falling during ISSUE or WAIT does not abort the current send; the block then holds in IDLE.
- tx_start_ram_addr holds its last value outside ISSUE.

## Timing
- Reset values: tx_cmd_send=0, tx_start_ram_addr=0, busy=0, fifo_level=0, drop_count=0, sent_count=0, slot_ptr=0, state=IDLE.
- Reset asserted mid-operation flushes the FIFO and aborts WAIT; no cmd_send is emitted after reset.
- Latency: rx_data_saved in cycle c, with an empty FIFO, enable=1 and state IDLE, gives tx_cmd_send in cycle c+2.
- Back-to-back spacing between tx_cmd_send pulses = wait_cnt + 2 cycles.
- wait_cnt is 10 bits wide: maximum 190 + GAP_CYCLES; GAP_CYCLES must be at most 833.
- fifo_level updates one cycle after the push or pop edge. A simultaneous push and pop leaves it unchanged.

## Configuration
- TX_SCHED_STATS_EN defined: drop_count and sent_count are implemented as described.
- TX_SCHED_STATS_EN undefined: both outputs are tied to 0, the counter logic is removed, and drop behaviour is otherwise unchanged.

## Structure
- Shared package tx_sched_pkg holds:
  - descriptor struct {addr[24:0], size[11:0]};
  - state enum {IDLE, ISSUE, WAIT};
  - constants MIN_FRAME=60, MAX_FRAME=1518, BEAT_BYTES=8.
- Sub-module sched_desc_fifo: synchronous FIFO of descriptors with push, pop, full, empty and level outputs. The scheduler FSM, slot pointer and counters stay in the top module.

## Test plan
- Single packet: size 64 in cycle 10 → tx_cmd_send in cycle 12 with addr 0x000000; busy falls after 20 WAIT cycles.
- Three packets of size 64 → addrs 0x000, 0x100, 0x200; cmd_send pulses 22 cycles apart; sent_count=3.
- Sizes 59 and 1519 → no sends, drop_count=2; the next valid packet uses slot 2, addr 0x200.
- FIFO overflow: enable=0, 10 packets pushed → fifo_level=8, drop_count=2. Then enable=1 → exactly 8 sends, addrs 0x000–0x700.
- Slot wrap: 17 valid packets → the 17th uses addr 0x000.
- Reset asserted during WAIT with 3 descriptors queued → all outputs return to reset values, and no cmd_send occurs after release until a new packet arrives.
